seg_scan_driver: RTL
====================

Name: seg_scan_driver

Overview:
- Display-side receiver for the view controller's outputs. Drives a six-digit time-multiplexed 7-segment bank on an 8-digit board and the 10-LED bar.
- Each of showLeft, showMiddle and showRight (0..63) is shown as two decimal digits with leading-zero blanking.
- Data is snapshotted once per scan frame so a frame never mixes old and new values. An optional blink gate dims the digits.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit stays lit (1 kHz digit rate at 50 MHz).
- BLINK_FRAMES, 83, full 6-digit frames per blink half-period.

Ports:
- cp  input  1  system clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- showLeft  input  6  left value, 0..63.
- showMiddle  input  6  middle value, 0..63.
- showRight  input  6  right value, 0..63.
- LEDMsg  input  10  LED pattern from the view controller.
- blink_en  input  1  1 = blink the digits (pause indication).
- an  output  8  digit anodes, active-low; an[7:6] are always 1.
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- led  output  10  registered copy of LEDMsg.

Behaviour:
- Reset applies on the cp edge where rst_n=0. Every register clears:
  - an=8'hFF, seg=7'h7F, led=0.
  - scan_cnt=0, digit=0, blink_cnt=0, phase=0.
  - Snapshots sL/sM/sR = 0.
- Reset mid-frame aborts the frame; the first cycle after reset starts at digit 0.
- Scan counter: scan_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit advances 0→1→…→5→0.
  - digit is the display state machine: six states, strictly cyclic, no other transitions.
- Snapshot: on any edge where scan_cnt==0 and digit==0 (including the first edge after reset), sL/sM/sR load showLeft/showMiddle/showRight. Input changes at any other time are ignored until the next frame.
- Digit map (tens = v/10, units = v%10, v 6-bit unsigned):
  - d0 = sR units on an[0]
  - d1 = sR tens on an[1]
  - d2 = sM units on an[2]
  - d3 = sM tens on an[3]
  - d4 = sL units on an[4]
  - d5 = sL tens on an[5]
- Tens blanking: a tens digit equal to 0 is blanked (an=8'hFF, seg=7'h7F). Units digits are always lit, so value 0 shows "0" and 63 shows "63".
- Segment code:
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
- Output latency: an/seg are registered from the current digit and snapshots, one cycle behind the internal state. Exactly one anode is low per cycle, or none when blanked.
- Blink:
  - While blink_en=1, blink_cnt counts frames (increments when digit 5 wraps to 0).
  - At BLINK_FRAMES-1 it wraps and phase toggles.
  - phase=1 forces an=8'hFF, seg=7'h7F; scanning and snapshotting continue.
  - blink_en=0 clears blink_cnt and phase on the next edge, so digits reappear one cycle later.
- LEDs: led <= LEDMsg every cycle, 1-cycle latency, never blinked.
- Simultaneous events: snapshot load and digit wrap on the same edge are legal. The loaded values are used starting from d0 of the new frame.

Test Plan (sim params SCAN_DIV=4, BLINK_FRAMES=2):
1. Reset: hold rst_n=0 with inputs toggling -> an=FF, seg=7F, led=000 throughout. Release -> from cycle 2, an=FE for 4 cycles.
2. Right=7, Middle=42, Left=0 -> repeating 24-cycle frame:
   - an=FE/seg=78 (4 cycles)
   - blank (4)
   - an=FB/seg=24 (4)
   - an=F7/seg=19 (4)
   - an=EF/seg=40 (4)
   - blank (4)
3. Tearing: change Middle 42→15 while d2 is lit -> d2/d3 still show 2/4 this frame; the next frame shows 5 (12) / 1 (79).
4. Blink: blink_en=1 -> digits lit for 48 cycles, an=FF for 48, repeating. Drop blink_en during a dark phase -> an active again 2 cycles later.
5. LEDs: LEDMsg=3A5 then 000 -> led=3A5 one cycle later, then 000, independent of blink_en.
6. Reset mid-scan: rst_n=0 while d3 is lit -> an=FF next edge; after release the scan restarts at d0 with a fresh snapshot.

Source files
------------

// File: rtl/seg_scan_driver_if.sv
// Bundle between the view controller and the 7-segment/LED display receiver.
// master drives the values to show; slave (the display driver) drives the pins.
interface seg_scan_driver_if;
  logic [5:0] showLeft;
  logic [5:0] showMiddle;
  logic [5:0] showRight;
  logic [9:0] LEDMsg;
  logic       blink_en;
  logic [7:0] an;
  logic [6:0] seg;
  logic [9:0] led;

  modport master (
    output showLeft, showMiddle, showRight, LEDMsg, blink_en,
    input  an, seg, led
  );

  modport slave (
    input  showLeft, showMiddle, showRight, LEDMsg, blink_en,
    output an, seg, led
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed six-digit 7-segment scanner plus LED bar register.
// an/seg/led are registered (1 cycle); no backpressure, inputs are snapshotted once per frame.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 83
) (
  input  logic              cp,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic [2:0] {D0, D1, D2, D3, D4, D5} digit_t;

  digit_t          r_digit;
  logic [CW-1:0]   r_scan_cnt;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_phase;
  logic [5:0]      r_sL, r_sM, r_sR;

  logic            w_scan_last;
  logic            w_snap;
  logic [5:0]      w_sL, w_sM, w_sR;
  logic [5:0]      w_val;
  logic [5:0]      w_bcd;
  logic            w_is_tens;
  logic            w_blank;

  function automatic logic [6:0] f_seg(input logic [5:0] b);
    case (b)
      6'd0:    f_seg = 7'h40;
      6'd1:    f_seg = 7'h79;
      6'd2:    f_seg = 7'h24;
      6'd3:    f_seg = 7'h30;
      6'd4:    f_seg = 7'h19;
      6'd5:    f_seg = 7'h12;
      6'd6:    f_seg = 7'h02;
      6'd7:    f_seg = 7'h78;
      6'd8:    f_seg = 7'h00;
      6'd9:    f_seg = 7'h10;
      default: f_seg = 7'h7F;
    endcase
  endfunction

  assign w_scan_last = (r_scan_cnt == CW'(SCAN_DIV - 1));
  assign w_snap      = (r_scan_cnt == '0) && (r_digit == D0);

  // Bypass the snapshot on its load edge so d0's first cycle already shows the new frame.
  assign w_sL = w_snap ? bus.showLeft   : r_sL;
  assign w_sM = w_snap ? bus.showMiddle : r_sM;
  assign w_sR = w_snap ? bus.showRight  : r_sR;

  always_comb begin
    w_val = w_sR;
    case (r_digit)
      D0, D1:  w_val = w_sR;
      D2, D3:  w_val = w_sM;
      D4, D5:  w_val = w_sL;
      default: w_val = w_sR;
    endcase
  end

  assign w_is_tens = r_digit[0];
  assign w_bcd     = w_is_tens ? (w_val / 6'd10) : (w_val % 6'd10);
  assign w_blank   = r_phase || (w_is_tens && (w_bcd == 6'd0));

  always_ff @(posedge cp) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit     <= D0;
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
      r_sL        <= '0;
      r_sM        <= '0;
      r_sR        <= '0;
      bus.an      <= 8'hFF;
      bus.seg     <= 7'h7F;
      bus.led     <= '0;
    end else begin
      bus.led <= bus.LEDMsg;

      if (w_snap) begin
        r_sL <= bus.showLeft;
        r_sM <= bus.showMiddle;
        r_sR <= bus.showRight;
      end

      if (w_scan_last) begin
        r_scan_cnt <= '0;
        case (r_digit)
          D0:      r_digit <= D1;
          D1:      r_digit <= D2;
          D2:      r_digit <= D3;
          D3:      r_digit <= D4;
          D4:      r_digit <= D5;
          default: r_digit <= D0;
        endcase
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end

      if (!bus.blink_en) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b0;
      end else if (w_scan_last && (r_digit == D5)) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end

      if (w_blank) begin
        bus.an  <= 8'hFF;
        bus.seg <= 7'h7F;
      end else begin
        bus.an  <= ~(8'd1 << r_digit);
        bus.seg <= f_seg(w_bcd);
      end
    end
  end
endmodule
